// File: rtl/adc16dv160_output_emulator.sv
// adc16dv160_output_emulator
//   Transmit-side model of an ADC16DV160 LVDS output. Produces one 16-bit
//   sample per ACLK as rise/fall bit pairs for SAME_EDGE ODDR primitives in
//   the pin wrapper. Samples come from an AXI-Stream slave (two samples per
//   beat) or from internal test patterns (ramp, alternating, constant).
//
// Ports
//   ACLK, ARESET      sample clock; asynchronous active-high reset
//   enable            1 = run, 0 = idle (output 0x0000, FIFO flushed)
//   mode              0 stream, 1 ramp, 2 alternating 0xAAAA/0x5555, 3 constant
//   const_value       sample used in mode 3
//   sync_in           rising edge restarts ramp / alternating phase
//   s_axis_*          AXIS slave; tdata[15:0] is sent first, tlast tags the
//                     second sample of the beat
//   dout_rise/fall    ODDR D1/D2: dout_rise[i] = sample[2i], dout_fall[i] = sample[2i+1]
//   frame_out         high while the tlast-tagged sample is on dout
//   underflow_cnt     saturating count of stream-mode cycles with an empty FIFO
module adc16dv160_output_emulator #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [15:0]      const_value,
  input  logic             sync_in,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [7:0]       dout_rise,
  output logic [7:0]       dout_fall,
  output logic             frame_out,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  // A beat needs two free entries, so at most DEPTH-2 may be occupied.
  localparam logic [OCC_W-1:0] ROOM_MAX = OCC_W'(FIFO_DEPTH - 2);

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_ALT    = 2'd2;

  localparam logic [15:0] ALT_A = 16'hAAAA;
  localparam logic [15:0] ALT_B = 16'h5555;

  logic [15:0]       fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_tag;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_nx;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  fifo_cnt;
  logic [OCC_W-1:0]  cnt_next;
  logic              room_ok;

  logic [15:0]       sample_q;
  logic [15:0]       ramp_cnt;
  logic              alt_phase;
  logic              sync_q;

  logic              stream_run;
  logic              flush;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              sync_rise;

  assign stream_run = enable && (mode == MODE_STREAM);
  assign flush      = !stream_run;
  assign fifo_empty = (fifo_cnt == '0);
  // room_ok is registered from occupancy, so tready never depends on this
  // cycle's pop; it is also 0 throughout reset.
  assign s_axis_tready = stream_run && room_ok;
  assign push       = s_axis_tvalid && s_axis_tready;
  assign pop        = stream_run && !fifo_empty;
  assign sync_rise  = sync_in && !sync_q;
  assign wr_ptr_nx  = wr_ptr + PTR_W'(1);

  always_comb begin
    cnt_next = fifo_cnt;
    if (push) cnt_next = cnt_next + OCC_W'(2);
    if (pop)  cnt_next = cnt_next - OCC_W'(1);
    if (flush) cnt_next = '0;
  end

  // Storage needs no reset; emptiness is tracked by fifo_cnt.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_data[wr_ptr]    <= s_axis_tdata[15:0];
      fifo_data[wr_ptr_nx] <= s_axis_tdata[31:16];
      fifo_tag[wr_ptr]     <= 1'b0;
      fifo_tag[wr_ptr_nx]  <= s_axis_tlast;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      room_ok       <= 1'b0;
      sample_q      <= '0;
      frame_out     <= 1'b0;
      underflow_cnt <= '0;
      ramp_cnt      <= '0;
      alt_phase     <= 1'b0;
      sync_q        <= 1'b0;
    end else begin
      sync_q   <= sync_in;
      fifo_cnt <= cnt_next;
      room_ok  <= (cnt_next <= ROOM_MAX);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(2);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end

      frame_out <= 1'b0;
      if (!enable) begin
        sample_q <= '0;
      end else begin
        case (mode)
          MODE_STREAM: begin
            if (!fifo_empty) begin
              sample_q  <= fifo_data[rd_ptr];
              frame_out <= fifo_tag[rd_ptr];
            end else if (underflow_cnt != {CNT_W{1'b1}}) begin
              // Empty FIFO: hold the last sample on the lanes.
              underflow_cnt <= underflow_cnt + CNT_W'(1);
            end
          end
          MODE_RAMP: begin
            if (sync_rise) begin
              sample_q <= '0;
              ramp_cnt <= 16'd1;
            end else begin
              sample_q <= ramp_cnt;
              ramp_cnt <= ramp_cnt + 16'd1;
            end
          end
          MODE_ALT: begin
            if (sync_rise) begin
              sample_q  <= ALT_A;
              alt_phase <= 1'b1;
            end else begin
              sample_q  <= alt_phase ? ALT_B : ALT_A;
              alt_phase <= ~alt_phase;
            end
          end
          default: sample_q <= const_value;
        endcase
      end
    end
  end

  // Even sample bits drive the rising-edge ODDR input, odd bits the falling.
  always_comb begin
    dout_rise = '0;
    dout_fall = '0;
    for (int i = 0; i < 8; i++) begin
      dout_rise[i] = sample_q[2*i];
      dout_fall[i] = sample_q[2*i+1];
    end
  end

endmodule
